// File: rtl/mux_n_pipe.sv
// Registered N-way word selector with valid/ready handshake, direct-select and auto-scan modes.
// Optional MUXP_PARITY_EN adds out_parity, the XOR of the captured word.
module mux_n_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SEL_BITS = 5,
  parameter int unsigned NUM_CH   = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WIDTH*NUM_CH-1:0]   data_in,
  input  logic [SEL_BITS-1:0]       select,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_BITS-1:0]       out_sel,
  output logic                      out_err,
  output logic                      out_last,
  output logic                      out_valid,
`ifdef MUXP_PARITY_EN
  output logic                      out_parity,
`endif
  input  logic                      out_ready
);

  // One extra bit so NUM_CH == 2**SEL_BITS is representable.
  localparam logic [SEL_BITS:0]   NumChExt = (SEL_BITS + 1)'(NUM_CH);
  localparam logic [SEL_BITS-1:0] LastPtr  = SEL_BITS'(NUM_CH - 1);

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_BITS-1:0] out_sel_q, out_sel_d;
  logic                out_err_q, out_err_d;
  logic                out_last_q, out_last_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_BITS-1:0] scan_ptr_q, scan_ptr_d;

  logic                accept;
  logic [SEL_BITS-1:0] idx;
  logic                in_range;
  logic                ptr_at_last;
  logic [WIDTH-1:0]    sel_word;

  assign in_ready    = !out_valid_q || out_ready;
  assign accept      = in_valid && in_ready;
  assign idx         = mode ? scan_ptr_q : select;
  assign in_range    = {1'b0, idx} < NumChExt;
  assign ptr_at_last = (scan_ptr_q == LastPtr);

  // Out-of-range indices match no channel and leave the word at zero.
  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (idx == SEL_BITS'(k)) begin
        sel_word = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_err_d   = out_err_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    scan_ptr_d  = scan_ptr_q;
    if (accept) begin
      out_data_d  = sel_word;
      out_sel_d   = idx;
      out_err_d   = !in_range;
      out_last_d  = mode && ptr_at_last;
      out_valid_d = 1'b1;
      if (mode) begin
        scan_ptr_d = ptr_at_last ? '0 : scan_ptr_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      scan_ptr_q  <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      scan_ptr_q  <= scan_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_err   = out_err_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

`ifdef MUXP_PARITY_EN
  logic out_parity_q, out_parity_d;

  // sel_word is zero on an error beat, so parity is zero there too.
  always_comb begin
    out_parity_d = out_parity_q;
    if (accept) begin
      out_parity_d = ^sel_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_parity_q <= 1'b0;
    end else begin
      out_parity_q <= out_parity_d;
    end
  end

  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Randomized scoreboard bench for mux_n_pipe (NUM_CH=5, so scan wraps at 4 and selects 5..31 are
// out of range). Build with MUXP_PARITY_EN to also check out_parity.
module tb_mux_n_pipe;

  localparam int unsigned W   = 32;
  localparam int unsigned SB  = 5;
  localparam int unsigned NCH = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [W*NCH-1:0] data_in = '0;
  logic [SB-1:0]   select = '0;
  logic            mode = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic [SB-1:0]   out_sel;
  logic            out_err;
  logic            out_last;
  logic            out_valid;
  logic            out_ready = 1'b0;
`ifdef MUXP_PARITY_EN
  logic            out_parity;
`endif

  always #5 clock = ~clock;

  mux_n_pipe #(
    .WIDTH    (W),
    .SEL_BITS (SB),
    .NUM_CH   (NCH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .select    (select),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_err   (out_err),
    .out_last  (out_last),
    .out_valid (out_valid),
`ifdef MUXP_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SB-1:0] sel;
    logic          err;
    logic          last;
    logic          par;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       last_exp = '0;
  int          total = 0;
  int          bad = 0;
  int          pending_new = 0;
  int unsigned model_ptr = 0;
  logic [W-1:0] chan [NCH];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // One cycle of stimulus; the expected beat is pushed when the model says it is accepted.
  task automatic cycle(input logic v, input logic m, input logic [SB-1:0] s, input logic r,
                       input logic rnd);
    logic        exp_ready;
    int unsigned idx;
    beat_t       b;
    @(posedge clock);
    #2;
    in_valid  = v;
    mode      = m;
    select    = s;
    out_ready = r;
    for (int k = 0; k < int'(NCH); k++) begin
      chan[k] = rnd ? $urandom : 32'hA000_0000 + k;
      data_in[k*W +: W] = chan[k];
    end
    #1;
    pending_new = 0;
    exp_ready = (exp_q.size() == 0) || r;
    check("in_ready", {63'b0, in_ready}, {63'b0, exp_ready});
    if (v && exp_ready) begin
      idx = m ? model_ptr : int'(s);
      if (idx < NCH) begin
        b.data = chan[idx];
        b.err  = 1'b0;
      end else begin
        b.data = '0;
        b.err  = 1'b1;
      end
      b.sel  = idx[SB-1:0];
      b.last = m && (idx == NCH - 1);
      b.par  = ^b.data;
      if (m) model_ptr = (model_ptr + 1) % NCH;
      exp_q.push_back(b);
      pending_new = 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    exp_q.delete();
    pending_new = 0;
    model_ptr   = 0;
    last_exp    = '0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("rst_valid", {63'b0, out_valid}, 64'd0);
    check("rst_data", {32'b0, out_data}, 64'd0);
    check("rst_sel", {59'b0, out_sel}, 64'd0);
    check("rst_err_last", {62'b0, out_err, out_last}, 64'd0);
  endtask

  // Monitor: compare the presented beat mid-cycle; pop it when the consumer takes it.
  initial begin
    int shown;
    forever begin
      @(negedge clock);
      if (!reset) begin
        shown = exp_q.size() - pending_new;
        check("out_valid", {63'b0, out_valid}, {63'b0, shown > 0});
        if (shown > 0 && out_valid) begin
          check("out_data", {32'b0, out_data}, {32'b0, exp_q[0].data});
          check("out_sel", {59'b0, out_sel}, {59'b0, exp_q[0].sel});
          check("out_err", {63'b0, out_err}, {63'b0, exp_q[0].err});
          check("out_last", {63'b0, out_last}, {63'b0, exp_q[0].last});
`ifdef MUXP_PARITY_EN
          check("out_parity", {63'b0, out_parity}, {63'b0, exp_q[0].par});
`endif
          if (out_ready) last_exp = exp_q.pop_front();
        end else if (shown == 0) begin
          check("idle_data", {32'b0, out_data}, {32'b0, last_exp.data});
        end
      end
    end
  end

  initial begin
    int drain;
    do_reset();

    // Direct hit, out-of-range, back in range.
    cycle(1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 5'd25, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 5'd4, 1'b1, 1'b0);

    // Full scan pass plus wrap.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 5'd0, 1'b1, 1'b1);

    // Backpressure then release.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 5'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 5'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);

    // Direct detour keeps scan pointer.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 5'(i * 7), 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 5'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 5'd0, 1'b1, 1'b1);

    // Reset while a beat is held.
    cycle(1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    do_reset();
    cycle(1'b1, 1'b1, 5'd0, 1'b1, 1'b1);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              $urandom_range(0, 3) != 0, 1'b1);
      end
    end

    drain = 0;
    while (exp_q.size() != 0 && drain < 10) begin
      cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      drain++;
    end
    @(negedge clock);
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
Parametrised, registered N-way word selector with a valid/ready handshake on both sides. It adds two things to the flat 32:1 combinational selector: a direct-select mode and an auto-scan mode, in which an internal pointer walks the channels. It sits between banks of per-channel registers (note lanes, register-file-style sources) and a single downstream consumer that may stall.

Parameters:
WIDTH, 32, bits per channel word
SEL_BITS, 5, width of select and pointer
NUM_CH, 32, number of channels; 1 <= NUM_CH <= 2**SEL_BITS, need not be a power of two

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH*NUM_CH  packed channels; channel k = data_in[k*WIDTH +: WIDTH]
select  input  SEL_BITS  channel index used in direct mode
mode  input  1  0 = direct select, 1 = scan
in_valid  input  1  request to capture one word
in_ready  output  1  block can accept a request this cycle
out_data  output  WIDTH  captured word
out_sel  output  SEL_BITS  index that produced out_data
out_err  output  1  index was out of range (>= NUM_CH)
out_last  output  1  beat was the final channel of a scan pass
out_valid  output  1  out_* fields hold a beat
out_ready  input  1  consumer takes the beat

Behaviour:
- One clock, named clock. reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values: out_valid=0, out_data=0, out_sel=0, out_err=0, out_last=0, scan_ptr=0. A reset asserted while a beat is held drops that beat with no handshake.
- in_ready = !out_valid || out_ready, a combinational pass-through of out_ready. No bubble: throughput is 1 beat per cycle while out_ready=1.
- Accept = in_valid && in_ready. On accept, all out_* fields register on the next edge (latency 1) and out_valid becomes 1.
- Effective index: idx = mode ? scan_ptr : select. data_in and select are sampled only on the accept edge.
- Out-of-range (direct mode only), when idx >= NUM_CH:
  - out_data=0, out_err=1, out_sel=idx.
  - The beat still completes the handshake.
- Scan mode:
  - scan_ptr advances by 1 on each accept.
  - At NUM_CH-1 it wraps to 0, and out_last=1 on that beat.
  - out_last is always 0 in direct mode.
- scan_ptr holds its value while mode=0, so returning to scan resumes where it left off. It only returns to 0 on reset or on a scan wrap.
- Hold: while out_valid && !out_ready, all out_* fields stay bit-stable and in_ready=0.
- Consume without a new accept: out_valid falls on the next edge and out_data keeps its last value.
- Simultaneous consume and accept in the same cycle: the new beat replaces the old one and out_valid stays 1.
- NUM_CH=1: scan_ptr stays 0 and every scan beat has out_last=1.
- The mode change takes effect on the cycle it is sampled together with an accept. mode has no effect when there is no accept.

Optional Feature:
MUXP_PARITY_EN
- Defined: adds output out_parity (1 bit) = XOR reduction of the selected word, registered together with out_data. Reset value 0. Held stable under backpressure. 0 on an out_err beat.
- Not defined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then direct mode, NUM_CH=32, channel k = 32'hA000_0000+k, select=7, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=32'hA000_0007, out_sel=7, out_err=0.
- Scan mode, NUM_CH=5, in_valid held 1, out_ready=1 -> out_sel sequence 0,1,2,3,4,0. out_last=1 only on the sel=4 beat. One beat per cycle.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_data/out_sel frozen. out_ready=1 -> the held beat is consumed and the next word is captured in the same cycle.
- Direct mode, NUM_CH=20, select=25 -> out_err=1, out_data=0, out_sel=25. Then select=3 -> out_err=0.
- Scan to ptr=2, switch to direct for 4 beats, return to scan -> next scan beat has out_sel=2. Then assert reset with out_valid=1 -> out_valid=0 and the following scan beat has out_sel=0.
- MUXP_PARITY_EN defined, selected word 32'h0000_0007 -> out_parity=1. Word 32'h0000_0003 -> out_parity=0.
